bus_ram_console: RTL

BUS_RAM_CONSOLE -- requirements
Module: bus_ram_console

---
 rtl/bus_ram_console.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bus_ram_console.sv
// Bus slave with a byte-lane RAM region and a console region that feeds a TX byte FIFO.
// Each transfer takes IDLE -> [WAIT] -> ACK, and the side effect is committed on the ACK edge.
module bus_ram_console #(
  parameter int          RAM_AW      = 16,
  parameter int          WAIT_STATES = 0,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [11:0] RAM_BASE    = 12'h000,
  parameter logic [11:0] CON_BASE    = 12'h100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [3:0]  lane,
  input  logic        wr,
  input  logic        valid,
  output logic        ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = PW + 1;
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;

  logic [31:0]     ram [2**RAM_AW];
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wp, rp;
  logic [LW-1:0]   level;
  logic            full;

  logic            ram_sel, con_sel;
  logic [RAM_AW-1:0] idx;
  logic            con_push_req, stall;
  logic            push, pop;
  logic            load_dout;
  logic [31:0]     status;
  logic            unused;

  assign ram_sel = (addr[31:20] == RAM_BASE);
  assign con_sel = (addr[31:20] == CON_BASE) && !ram_sel;
  assign idx     = addr[RAM_AW+1:2];
  assign unused  = ^{addr[1:0], addr[19:2]};

  assign con_push_req = wr && con_sel && !addr[2];
  assign stall        = con_push_req && full;

  // Control FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (valid) begin
          // With no wait states a full FIFO still has to be waited out, so park in WAIT.
          if (WAIT_STATES == 0 && !stall) begin
            state_nx = ACK;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!valid) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (!stall) begin
          state_nx = ACK;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign ready     = (state == ACK);
  assign load_dout = (state != ACK) && (state_nx == ACK) && !wr;

  assign full   = (level == LW'(FIFO_DEPTH));
  assign status = {full, {(31-LW){1'b0}}, level};

  // Read data is captured on the edge entering ACK so it is present while ready is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= 32'h0;
    end else if (load_dout) begin
      if (ram_sel)      dout <= ram[idx];
      else if (con_sel) dout <= addr[2] ? status : 32'h0;
      else              dout <= 32'hDEAD_BEEF;
    end
  end

  always_ff @(posedge clk) begin
    if (ready && wr && ram_sel) begin
      for (int n = 0; n < 4; n++) begin
        if (lane[n]) ram[idx][8*n +: 8] <= din[8*n +: 8];
      end
    end
  end

  // Console TX FIFO
  assign push     = ready && con_push_req;
  assign tx_valid = (level != '0);
  assign pop      = tx_valid && tx_ready;
  assign tx_data  = tx_valid ? fifo_mem[rp] : 8'h00;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp] <= din[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
